// File: rtl/async_flit_injector_if.sv
// ---------------------------------------------------------------------------
// async_flit_injector_if
//   Bundled-data 4-phase link between the clocked flit injector and one input
//   port of the asynchronous switch.
//
//   Signals
//     req   : 4-phase request, driven by the injector (registered, glitch-free)
//     data  : bundled flit data, stable whenever req or ack is high
//     ack   : 4-phase acknowledge, driven by the switch (asynchronous to clk)
//
//   Modports
//     master : the injector side (drives req/data, observes ack)
//     slave  : the switch side  (observes req/data, drives ack)
// ---------------------------------------------------------------------------
interface async_flit_injector_if #(
    parameter int WIDTH = 128
);
    logic             req;
    logic [WIDTH-1:0] data;
    logic             ack;

    modport master (
        output req,
        output data,
        input  ack
    );

    modport slave (
        input  req,
        input  data,
        output ack
    );
endinterface

// File: rtl/async_flit_injector.sv
// ---------------------------------------------------------------------------
// async_flit_injector
//   Traffic-generator end of one switch input port. Builds packets (head,
//   body..., tail, or a single head+tail flit) and pushes them one flit at a
//   time over a bundled-data 4-phase req/ack channel. The switch's ack is
//   asynchronous, so it is brought into the clk domain through a flop
//   synchronizer and every FSM decision is taken on the synchronized copy.
//
//   Ports
//     clk         : single clock
//     reset       : asynchronous, active-low reset
//     gen_enable  : level, 1 = start/continue generating packets
//     dest_x      : destination X, sampled at packet start
//     dest_y      : destination Y, sampled at packet start
//     pkt_len     : flits per packet, sampled at packet start (0 -> 1)
//     link        : master side of the req/data/ack channel
//     busy_o      : 1 while a packet is in flight
//     flit_cnt_o  : flits completed (ack fell), wraps
//     pkt_cnt_o   : packets completed (tail ack fell), wraps
//
//   Flit layout (top two bits are the flit type)
//     head/single : [W-3 -: X_BITS]=dest_x, then Y_BITS of dest_y,
//                   [15:0] = packets completed so far, rest 0
//     body/tail   : [31:0] = payload LFSR state, rest 0
//
//   Per-flit handshake
//     SETUP  : data is already stable, req held low one cycle as bundling
//              margin before req rises
//     REQ_HI : req=1 until synchronized ack rises
//     REQ_LO : req=0 until synchronized ack falls; the flit is then complete
// ---------------------------------------------------------------------------
module async_flit_injector #(
    parameter int          WIDTH       = 128,
    parameter int          X_BITS      = 2,
    parameter int          Y_BITS      = 2,
    parameter int          LEN_BITS    = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gen_enable,
    input  logic [X_BITS-1:0]       dest_x,
    input  logic [Y_BITS-1:0]       dest_y,
    input  logic [LEN_BITS-1:0]     pkt_len,
    async_flit_injector_if.master   link,
    output logic                    busy_o,
    output logic [31:0]             flit_cnt_o,
    output logic [15:0]             pkt_cnt_o
);

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b01;
    localparam logic [1:0] TYPE_HEAD   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting)
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_REQ_LO = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] make_head(
        input logic [1:0]        ftype,
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y,
        input logic [15:0]       seq
    );
        logic [WIDTH-1:0] f;
        f                            = '0;
        f[WIDTH-1 -: 2]              = ftype;
        f[WIDTH-3 -: X_BITS]         = x;
        f[WIDTH-3-X_BITS -: Y_BITS]  = y;
        f[15:0]                      = seq;
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] make_payload(
        input logic [1:0]  ftype,
        input logic [31:0] lfsr
    );
        logic [WIDTH-1:0] f;
        f               = '0;
        f[WIDTH-1 -: 2] = ftype;
        f[31:0]         = lfsr;
        return f;
    endfunction

    // ---------------------------------------------------------------------
    // ack synchronizer: ack arrives from the self-timed switch with no
    // relation to clk, so only the last stage is ever looked at.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], link.ack};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Packet / handshake state
    // ---------------------------------------------------------------------
    state_t              r_state;
    logic                r_req;
    logic [WIDTH-1:0]    r_data;
    logic [LEN_BITS-1:0] r_remaining;
    logic                r_is_last;     // current flit is tail or single
    logic                r_is_payload;  // current flit is body or tail
    logic [31:0]         r_lfsr;
    logic [31:0]         r_flit_cnt;
    logic [15:0]         r_pkt_cnt;

    logic [LEN_BITS-1:0] w_len_eff;
    logic [LEN_BITS-1:0] w_rem_dec;
    logic [31:0]         w_lfsr_adv;
    logic                w_next_is_tail;

    // A zero length would never reach a tail, so it is promoted to one flit.
    assign w_len_eff      = (pkt_len == '0) ? LEN_BITS'(1) : pkt_len;
    assign w_rem_dec      = r_remaining - LEN_BITS'(1);
    assign w_next_is_tail = (w_rem_dec == LEN_BITS'(1));

    // The LFSR only moves when a payload flit completes; the flit that
    // follows is loaded in the same edge, so it takes the advanced value.
    assign w_lfsr_adv     = r_is_payload ? lfsr_step(r_lfsr) : r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_data       <= '0;
            r_remaining  <= '0;
            r_is_last    <= 1'b0;
            r_is_payload <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_flit_cnt   <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A high ack_s here is a leftover handshake from before
                    // reset; starting now would collide with it.
                    if (gen_enable && !w_ack_s) begin
                        r_remaining  <= w_len_eff;
                        r_is_last    <= (w_len_eff == LEN_BITS'(1));
                        r_is_payload <= 1'b0;
                        r_data       <= make_head(
                                            (w_len_eff == LEN_BITS'(1)) ? TYPE_SINGLE : TYPE_HEAD,
                                            dest_x, dest_y, r_pkt_cnt);
                        r_state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // data has been stable for this whole cycle with req low
                    r_req   <= 1'b1;
                    r_state <= ST_REQ_HI;
                end

                ST_REQ_HI: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= ST_REQ_LO;
                    end
                end

                ST_REQ_LO: begin
                    if (!w_ack_s) begin
                        r_flit_cnt  <= r_flit_cnt + 32'd1;
                        r_remaining <= w_rem_dec;
                        r_lfsr      <= w_lfsr_adv;
                        if (r_is_last) begin
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_is_payload <= 1'b1;
                            r_is_last    <= w_next_is_tail;
                            r_data       <= make_payload(
                                                w_next_is_tail ? TYPE_TAIL : TYPE_BODY,
                                                w_lfsr_adv);
                            r_state      <= ST_SETUP;
                        end
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign link.req   = r_req;
    assign link.data  = r_data;
    assign busy_o     = (r_state != ST_IDLE);
    assign flit_cnt_o = r_flit_cnt;
    assign pkt_cnt_o  = r_pkt_cnt;

endmodule

// File: tb/tb_async_flit_injector.sv
module tb_async_flit_injector;

    localparam int          W       = 128;
    localparam int          XB      = 2;
    localparam int          YB      = 2;
    localparam int          LB      = 4;
    localparam int          SS      = 2;
    localparam logic [31:0] SEED    = 32'hACE1_0001;
    localparam int          TIMEOUT = 300;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gen_enable = 1'b0;
    logic [XB-1:0] dest_x = '0;
    logic [YB-1:0] dest_y = '0;
    logic [LB-1:0] pkt_len = '0;
    logic          busy_o;
    logic [31:0]   flit_cnt_o;
    logic [15:0]   pkt_cnt_o;

    async_flit_injector_if #(.WIDTH(W)) link ();

    always #5 clk = ~clk;

    async_flit_injector #(
        .WIDTH(W), .X_BITS(XB), .Y_BITS(YB), .LEN_BITS(LB),
        .SYNC_STAGES(SS), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .gen_enable(gen_enable),
        .dest_x(dest_x), .dest_y(dest_y), .pkt_len(pkt_len),
        .link(link), .busy_o(busy_o),
        .flit_cnt_o(flit_cnt_o), .pkt_cnt_o(pkt_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   m_lfsr = SEED;
    logic [31:0]   m_flit = 0;
    logic [15:0]   m_pkt  = 0;

    // Reference model ----------------------------------------------------
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic push_packet(input logic [XB-1:0] x, input logic [YB-1:0] y,
                               input logic [LB-1:0] len);
        int           eff;
        logic [W-1:0] f;
        eff = (len == 0) ? 1 : int'(len);
        for (int i = 0; i < eff; i++) begin
            f = '0;
            if (i == 0) begin
                f[W-1 -: 2]        = (eff == 1) ? 2'b11 : 2'b10;
                f[W-3 -: XB]       = x;
                f[W-3-XB -: YB]    = y;
                f[15:0]            = m_pkt;
            end else begin
                f[W-1 -: 2] = (i == eff - 1) ? 2'b01 : 2'b00;
                f[31:0]     = m_lfsr;
                m_lfsr      = lfsr_next(m_lfsr);
            end
            exp_q.push_back(f);
        end
        m_pkt  = m_pkt + 16'd1;
        m_flit = m_flit + 32'(eff);
    endtask

    // Starts one packet, then scrambles the sampled inputs to show they
    // are ignored once the packet is underway.
    task automatic start_packet(input logic [XB-1:0] x, input logic [YB-1:0] y,
                                input logic [LB-1:0] len);
        dest_x = x; dest_y = y; pkt_len = len; gen_enable = 1'b1;
        push_packet(x, y, len);
        @(negedge clk);
        gen_enable = 1'b0;
        dest_x = ~x; dest_y = ~y; pkt_len = len + 4'd3;
    endtask

    // Switch-side responder for one flit ----------------------------------
    task automatic serve_flit(input int delay, output logic [W-1:0] d);
        int n;
        d = 'x;
        n = 0;
        while (link.req !== 1'b1 && n < TIMEOUT) begin @(negedge clk); n++; end
        if (link.req !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_rise_timeout: req=%b required 1", link.req);
            return;
        end
        d = link.data;
        repeat (delay) @(negedge clk);
        link.ack = 1'b1;
        n = 0;
        while (link.req !== 1'b0 && n < TIMEOUT) begin @(negedge clk); n++; end
        if (link.req !== 1'b0) begin
            checks++; errors++;
            $display("FAIL req_fall_timeout: req=%b required 0", link.req);
        end
        repeat (delay) @(negedge clk);
        link.ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < TIMEOUT) begin @(negedge clk); n++; end
        if (busy_o !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy_o=%b required 0", busy_o);
        end
    endtask

    // Bundling-rule monitor ----------------------------------------------
    logic [SS-1:0] m_sync;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_sync <= '0;
        else        m_sync <= {m_sync[SS-2:0], link.ack};
    end

    initial begin
        logic         p_valid;
        logic         p_req;
        logic         p_acks;
        logic [W-1:0] p_data;
        p_valid = 1'b0; p_req = 1'b0; p_acks = 1'b0; p_data = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && p_valid) begin
                if (p_req || p_acks) begin
                    checks++;
                    if (link.data !== p_data) begin
                        errors++;
                        $display("FAIL data_stable: data=%h required %h (req/ack_s high)", link.data, p_data);
                    end
                end
                if (link.req === 1'b1 && !p_req) begin
                    checks++;
                    if (link.data !== p_data) begin
                        errors++;
                        $display("FAIL bundling_margin: data=%h at req rise required %h", link.data, p_data);
                    end
                end
            end
            p_valid = (reset === 1'b1);
            p_req   = link.req;
            p_acks  = m_sync[SS-1];
            p_data  = link.data;
        end
    end

    // Tests --------------------------------------------------------------
    task automatic test_reset();
        int  n;
        logic seen;
        reset = 1'b0; link.ack = 1'b1; gen_enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (link.req !== 1'b0)   begin errors++; $display("FAIL reset_req: got %b required 0", link.req); end
        checks++; if (link.data !== '0)    begin errors++; $display("FAIL reset_data: got %h required 0", link.data); end
        checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        checks++; if (flit_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_flit_cnt: got %0d required 0", flit_cnt_o); end
        checks++; if (pkt_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt_o); end
        reset = 1'b1;
        repeat (SS + 2) @(negedge clk);
        // stale ack still high: the request must be held off
        dest_x = 2'd2; dest_y = 2'd1; pkt_len = 4'd1; gen_enable = 1'b1;
        push_packet(2'd2, 2'd1, 4'd1);
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (link.req !== 1'b0 || busy_o !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL stale_ack_hold: req/busy rose while ack high, required 0"); end
        link.ack = 1'b0;
        n = 0;
        while (link.req !== 1'b1 && n < TIMEOUT) begin @(negedge clk); n++; end
        gen_enable = 1'b0;
        checks++;
        if (n != SS + 2) begin errors++; $display("FAIL stale_ack_release: req after %0d clk required %0d", n, SS + 2); end
        $display("test_reset: req released %0d clk after ack low", n);
    endtask

    task automatic test_single_flit();
        logic [W-1:0] d, e;
        serve_flit(5, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL single_flit: got %h required %h", d, e); end
        checks++; if (d[W-1 -: 2] !== 2'b11) begin errors++; $display("FAIL single_type: got %b required 11", d[W-1 -: 2]); end
        checks++; if (d[W-3 -: XB] !== 2'd2 || d[W-3-XB -: YB] !== 2'd1) begin
            errors++; $display("FAIL single_dest: got (%0d,%0d) required (2,1)", d[W-3 -: XB], d[W-3-XB -: YB]); end
        wait_idle();
        checks++; if (pkt_cnt_o !== 16'd1 || flit_cnt_o !== 32'd1) begin
            errors++; $display("FAIL single_counts: got pkt=%0d flit=%0d required 1/1", pkt_cnt_o, flit_cnt_o); end
        $display("test_single_flit: flit %h", d);
    endtask

    task automatic test_multi(input logic [XB-1:0] x, input logic [YB-1:0] y,
                              input logic [LB-1:0] len, input string name);
        logic [W-1:0] d, e;
        int           eff;
        eff = (len == 0) ? 1 : int'(len);
        start_packet(x, y, len);
        for (int i = 0; i < eff; i++) begin
            serve_flit(int'($urandom_range(20, 0)), d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL %s flit %0d: got %h required %h", name, i, d, e); end
            $display("%s: flit %0d data %h", name, i, d);
        end
        checks++;
        if (d[W-1 -: 2] !== ((eff == 1) ? 2'b11 : 2'b01)) begin
            errors++; $display("FAIL %s last_type: got %b", name, d[W-1 -: 2]); end
        wait_idle();
        checks++;
        if (flit_cnt_o !== m_flit || pkt_cnt_o !== m_pkt) begin
            errors++; $display("FAIL %s counts: got flit=%0d pkt=%0d required %0d/%0d", name, flit_cnt_o, pkt_cnt_o, m_flit, m_pkt); end
    endtask

    task automatic test_enable_drop();
        logic [W-1:0] d, e;
        logic         seen;
        dest_x = 2'd3; dest_y = 2'd2; pkt_len = 4'd3; gen_enable = 1'b1;
        push_packet(2'd3, 2'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            serve_flit(int'($urandom_range(20, 0)), d);
            if (i == 0) gen_enable = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL enable_drop flit %0d: got %h required %h", i, d, e); end
            $display("test_enable_drop: flit %0d data %h", i, d);
        end
        wait_idle();
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (busy_o !== 1'b0 || link.req !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL enable_drop_idle: activity after packet, required none"); end
        checks++;
        if (flit_cnt_o !== m_flit || pkt_cnt_o !== m_pkt) begin
            errors++; $display("FAIL enable_drop counts: got %0d/%0d required %0d/%0d", flit_cnt_o, pkt_cnt_o, m_flit, m_pkt); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, e;
        dest_x = 2'd1; dest_y = 2'd1; pkt_len = 4'd2; gen_enable = 1'b1;
        push_packet(2'd1, 2'd1, 4'd2);
        push_packet(2'd1, 2'd1, 4'd2);
        for (int i = 0; i < 4; i++) begin
            serve_flit(int'($urandom_range(6, 0)), d);
            if (i == 2) gen_enable = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL back_to_back flit %0d: got %h required %h", i, d, e); end
            $display("test_back_to_back: flit %0d data %h", i, d);
        end
        wait_idle();
        checks++;
        if (flit_cnt_o !== m_flit || pkt_cnt_o !== m_pkt) begin
            errors++; $display("FAIL back_to_back counts: got %0d/%0d required %0d/%0d", flit_cnt_o, pkt_cnt_o, m_flit, m_pkt); end
    endtask

    task automatic test_reset_mid_handshake();
        int n;
        start_packet(2'd2, 2'd2, 4'd3);
        n = 0;
        while (link.req !== 1'b1 && n < TIMEOUT) begin @(negedge clk); n++; end
        checks++; if (link.req !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: req=%b required 1", link.req); end
        reset = 1'b0;
        #1;
        checks++; if (link.req !== 1'b0)    begin errors++; $display("FAIL mid_reset_req: got %b required 0", link.req); end
        checks++; if (link.data !== '0)     begin errors++; $display("FAIL mid_reset_data: got %h required 0", link.data); end
        checks++; if (flit_cnt_o !== 32'd0 || pkt_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_counts: got flit=%0d pkt=%0d busy=%b required 0", flit_cnt_o, pkt_cnt_o, busy_o); end
        $display("test_reset_mid_handshake: req=%b data=%h", link.req, link.data);
        exp_q.delete();
        m_lfsr = SEED; m_flit = 0; m_pkt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // LFSR restarts from its seed after reset
        test_multi(2'd1, 2'd2, 4'd2, "post_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        link.ack = 1'b0;
        test_reset();
        test_single_flit();
        test_multi(2'd1, 2'd3, 4'd4,  "test_four_flit");
        test_multi(2'd3, 2'd0, 4'd0,  "test_len_zero");
        test_multi(2'd0, 2'd2, 4'd15, "test_len_max");
        test_enable_drop();
        test_back_to_back();
        test_reset_mid_handshake();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
